// File: rtl/viewport_pkg.sv
// Shared types and helpers for the viewport coordinate generator.
// The saturation helpers are only referenced when COORD_SATURATE_EN is defined.
package viewport_pkg;

  localparam int COORD_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } vp_state_e;

  // Accumulator width: enough headroom to step across a full line or column
  // without losing the sign, even if the low COORD_W bits wrap.
  function automatic int acc_w(input int coord_w, input int h_res, input int v_res);
    int m;
    m = (h_res > v_res) ? h_res : v_res;
    return coord_w + $clog2(m) + 1;
  endfunction

  // Largest representable signed coordinate of width w.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest representable signed coordinate of width w.
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/viewport_coord_gen_sat.sv
// coord_sat: clamps a wide signed accumulator to a signed COORD_W coordinate.
// Only instantiated when COORD_SATURATE_EN is defined.
module coord_sat
  import viewport_pkg::*;
#(
  parameter int ACC_W   = 23,
  parameter int COORD_W = 16
) (
  input  logic signed [ACC_W-1:0]   acc,
  output logic signed [COORD_W-1:0] coord
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(COORD_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(COORD_W));

  // Clamp out-of-range accumulator values, pass everything else through.
  always_comb begin
    coord = acc[COORD_W-1:0];
    if (acc > MAX_V) begin
      coord = MAX_V[COORD_W-1:0];
    end else if (acc < MIN_V) begin
      coord = MIN_V[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/viewport_coord_gen.sv
// viewport_coord_gen: raster walker that emits one signed complex-plane
// coordinate per pixel with SOF/EOL/last-line markers, AXI-Stream handshake.
// Optional build macro COORD_SATURATE_EN: clamp x/y instead of wrapping.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no frame in flight, valid=0, waits for enable
// RUN   | frame in flight, one pixel presented, advances on valid&ready
module viewport_coord_gen
  import viewport_pkg::*;
#(
  parameter int H_RES   = 640,
  parameter int V_RES   = 480,
  parameter int COORD_W = COORD_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic signed [COORD_W-1:0] cfg_origin_x,
  input  logic signed [COORD_W-1:0] cfg_origin_y,
  input  logic        [COORD_W-1:0] cfg_step,
  input  logic                      ready,
  output logic                      valid,
  output logic signed [COORD_W-1:0] x,
  output logic signed [COORD_W-1:0] y,
  output logic                      first,
  output logic                      lastx,
  output logic                      lasty,
  output logic                      busy
);

  localparam int ACC_W = acc_w(COORD_W, H_RES, V_RES);
  // A one-pixel axis still needs a 1-bit counter to keep the logic legal.
  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(H_RES - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);

  vp_state_e                  state, state_nxt;
  logic                       valid_nxt, first_nxt, lastx_nxt, lasty_nxt;
  logic [CW-1:0]              col, col_nxt;
  logic [RW-1:0]              row, row_nxt;
  logic signed [ACC_W-1:0]    acc_x, acc_x_nxt, acc_y, acc_y_nxt;
  logic signed [COORD_W-1:0]  ox_sh, ox_sh_nxt;
  logic        [COORD_W-1:0]  step_sh, step_sh_nxt;
  logic                       start;

  logic signed [ACC_W-1:0]    step_ext, ox_sh_ext, ox_cfg_ext, oy_cfg_ext;

  assign step_ext   = signed'({{(ACC_W-COORD_W){1'b0}}, step_sh});
  assign ox_sh_ext  = {{(ACC_W-COORD_W){ox_sh[COORD_W-1]}}, ox_sh};
  assign ox_cfg_ext = {{(ACC_W-COORD_W){cfg_origin_x[COORD_W-1]}}, cfg_origin_x};
  assign oy_cfg_ext = {{(ACC_W-COORD_W){cfg_origin_y[COORD_W-1]}}, cfg_origin_y};

  // Next-state, raster advance and marker computation.
  always_comb begin
    state_nxt   = state;
    valid_nxt   = valid;
    col_nxt     = col;
    row_nxt     = row;
    acc_x_nxt   = acc_x;
    acc_y_nxt   = acc_y;
    ox_sh_nxt   = ox_sh;
    step_sh_nxt = step_sh;
    start       = 1'b0;

    case (state)
      IDLE: begin
        if (enable) start = 1'b1;
      end
      RUN: begin
        if (valid && ready) begin
          if (col != COL_LAST) begin
            col_nxt   = col + CW'(1);
            acc_x_nxt = acc_x + step_ext;
          end else if (row != ROW_LAST) begin
            col_nxt   = '0;
            row_nxt   = row + RW'(1);
            acc_x_nxt = ox_sh_ext;
            acc_y_nxt = acc_y - step_ext;
          end else if (enable) begin
            start = 1'b1;
          end else begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
      end
    endcase

    // Frame start: the viewport is sampled here only, so it never tears.
    if (start) begin
      state_nxt   = RUN;
      valid_nxt   = 1'b1;
      col_nxt     = '0;
      row_nxt     = '0;
      ox_sh_nxt   = cfg_origin_x;
      step_sh_nxt = cfg_step;
      acc_x_nxt   = ox_cfg_ext;
      acc_y_nxt   = oy_cfg_ext;
    end

    first_nxt = valid_nxt && (col_nxt == '0) && (row_nxt == '0);
    lastx_nxt = valid_nxt && (col_nxt == COL_LAST);
    lasty_nxt = valid_nxt && (row_nxt == ROW_LAST);
  end

  // State, counters, accumulators and markers all update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      valid   <= 1'b0;
      first   <= 1'b0;
      lastx   <= 1'b0;
      lasty   <= 1'b0;
      col     <= '0;
      row     <= '0;
      acc_x   <= '0;
      acc_y   <= '0;
      ox_sh   <= '0;
      step_sh <= '0;
    end else begin
      state   <= state_nxt;
      valid   <= valid_nxt;
      first   <= first_nxt;
      lastx   <= lastx_nxt;
      lasty   <= lasty_nxt;
      col     <= col_nxt;
      row     <= row_nxt;
      acc_x   <= acc_x_nxt;
      acc_y   <= acc_y_nxt;
      ox_sh   <= ox_sh_nxt;
      step_sh <= step_sh_nxt;
    end
  end

  assign busy = (state == RUN);

`ifdef COORD_SATURATE_EN
  coord_sat #(.ACC_W(ACC_W), .COORD_W(COORD_W)) u_sat_x (.acc(acc_x), .coord(x));
  coord_sat #(.ACC_W(ACC_W), .COORD_W(COORD_W)) u_sat_y (.acc(acc_y), .coord(y));
`else
  assign x = acc_x[COORD_W-1:0];
  assign y = acc_y[COORD_W-1:0];
`endif

endmodule

// File: tb/tb_viewport_coord_gen.sv
// Directed bench for viewport_coord_gen: 4x3 raster instance plus a 1x1 instance.
module tb_viewport_coord_gen;

  logic        clk = 1'b0;
  logic        reset, enable, enable_b, ready;
  logic [15:0] cfg_origin_x, cfg_origin_y, cfg_step;

  logic        valid_a, first_a, lastx_a, lasty_a, busy_a;
  logic [15:0] x_a, y_a;
  logic        valid_b, first_b, lastx_b, lasty_b, busy_b;
  logic [15:0] x_b, y_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  viewport_coord_gen #(.H_RES(4), .V_RES(3), .COORD_W(16)) dut_a (
    .clk(clk), .reset(reset), .enable(enable),
    .cfg_origin_x(cfg_origin_x), .cfg_origin_y(cfg_origin_y), .cfg_step(cfg_step),
    .ready(ready), .valid(valid_a), .x(x_a), .y(y_a),
    .first(first_a), .lastx(lastx_a), .lasty(lasty_a), .busy(busy_a)
  );

  viewport_coord_gen #(.H_RES(1), .V_RES(1), .COORD_W(16)) dut_b (
    .clk(clk), .reset(reset), .enable(enable_b),
    .cfg_origin_x(cfg_origin_x), .cfg_origin_y(cfg_origin_y), .cfg_step(cfg_step),
    .ready(ready), .valid(valid_b), .x(x_b), .y(y_b),
    .first(first_b), .lastx(lastx_b), .lasty(lasty_b), .busy(busy_b)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected pixel p of the 4x3 raster, step 64, origin_y 128.
  task automatic expect_pix(input string f, input int p, input int ox);
    int c, r;
    logic [15:0] ex, ey;
    c  = p % 4;
    r  = p / 4;
    ex = 16'(ox + 64 * c);
    ey = 16'(128 - 64 * r);
    check_val($sformatf("%s_p%0d_valid", f, p), 32'(valid_a), 32'd1);
    check_val($sformatf("%s_p%0d_x", f, p), 32'(x_a), 32'(ex));
    check_val($sformatf("%s_p%0d_y", f, p), 32'(y_a), 32'(ey));
    check_val($sformatf("%s_p%0d_first", f, p), 32'(first_a), 32'(p == 0));
    check_val($sformatf("%s_p%0d_lastx", f, p), 32'(lastx_a), 32'(c == 3));
    check_val($sformatf("%s_p%0d_lasty", f, p), 32'(lasty_a), 32'(r == 2));
  endtask

  logic [15:0] ovf_x [4];

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    enable_b     = 1'b0;
    ready        = 1'b1;
    cfg_origin_x = 16'hFF00;
    cfg_origin_y = 16'h0080;
    cfg_step     = 16'h0040;
    repeat (2) tick();

    check_val("rst_valid", 32'(valid_a), 32'd0);
    check_val("rst_x", 32'(x_a), 32'd0);
    check_val("rst_y", 32'(y_a), 32'd0);
    check_val("rst_first", 32'(first_a), 32'd0);
    check_val("rst_lastx", 32'(lastx_a), 32'd0);
    check_val("rst_lasty", 32'(lasty_a), 32'd0);
    check_val("rst_busy", 32'(busy_a), 32'd0);
    check_val("rst_b_valid", 32'(valid_b), 32'd0);

    reset = 1'b0;
    tick();
    check_val("idle_busy", 32'(busy_a), 32'd0);
    enable = 1'b1;
    check_val("latency_valid", 32'(valid_a), 32'd0);
    tick();
    check_val("run_busy", 32'(busy_a), 32'd1);

    // Frame 1: backpressure at pixel 5, origin_x rewritten mid-frame.
    for (int p = 0; p < 12; p++) begin
      expect_pix("f1", p, -256);
      if (p == 2) cfg_origin_x = 16'h0000;
      if (p == 5) begin
        ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          expect_pix("stall", 5, -256);
        end
        ready = 1'b1;
      end
      tick();
    end

    // Frame 2 follows without a bubble and uses the new origin; enable drops at pixel 9.
    for (int p = 0; p < 12; p++) begin
      expect_pix("f2", p, 0);
      if (p == 9) enable = 1'b0;
      tick();
    end
    check_val("end_valid", 32'(valid_a), 32'd0);
    check_val("end_busy", 32'(busy_a), 32'd0);
    check_val("end_first", 32'(first_a), 32'd0);
    tick();
    check_val("idle_hold_valid", 32'(valid_a), 32'd0);

    // Mid-frame reset at pixel 6.
    cfg_origin_x = 16'hFF00;
    enable       = 1'b1;
    tick();
    for (int p = 0; p < 6; p++) begin
      expect_pix("f3", p, -256);
      tick();
    end
    expect_pix("f3", 6, -256);
    reset = 1'b1;
    tick();
    check_val("mrst_valid", 32'(valid_a), 32'd0);
    check_val("mrst_x", 32'(x_a), 32'd0);
    check_val("mrst_y", 32'(y_a), 32'd0);
    check_val("mrst_first", 32'(first_a), 32'd0);
    check_val("mrst_lastx", 32'(lastx_a), 32'd0);
    check_val("mrst_lasty", 32'(lasty_a), 32'd0);
    check_val("mrst_busy", 32'(busy_a), 32'd0);
    reset = 1'b0;
    tick();
    expect_pix("f4", 0, -256);
    tick();
    expect_pix("f4", 1, -256);

    // Overflow of the real axis.
`ifdef COORD_SATURATE_EN
    ovf_x[0] = 16'h7FC0; ovf_x[1] = 16'h7FFF; ovf_x[2] = 16'h7FFF; ovf_x[3] = 16'h7FFF;
`else
    ovf_x[0] = 16'h7FC0; ovf_x[1] = 16'h8000; ovf_x[2] = 16'h8040; ovf_x[3] = 16'h8080;
`endif
    reset = 1'b1;
    tick();
    reset        = 1'b0;
    cfg_origin_x = 16'h7FC0;
    tick();
    for (int c = 0; c < 4; c++) begin
      check_val($sformatf("ovf_c%0d_x", c), 32'(x_a), 32'(ovf_x[c]));
      check_val($sformatf("ovf_c%0d_y", c), 32'(y_a), 32'h0080);
      tick();
    end
    enable = 1'b0;

    // 1x1 raster: every pixel is its own frame, relatched every cycle.
    cfg_origin_x = 16'h0100;
    cfg_origin_y = 16'hFF00;
    enable_b     = 1'b1;
    check_val("b_latency_valid", 32'(valid_b), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val($sformatf("b%0d_valid", k), 32'(valid_b), 32'd1);
      check_val($sformatf("b%0d_first", k), 32'(first_b), 32'd1);
      check_val($sformatf("b%0d_lastx", k), 32'(lastx_b), 32'd1);
      check_val($sformatf("b%0d_lasty", k), 32'(lasty_b), 32'd1);
      check_val($sformatf("b%0d_busy", k), 32'(busy_b), 32'd1);
      check_val($sformatf("b%0d_x", k), 32'(x_b), 32'(16'h0100 * (k + 1)));
      check_val($sformatf("b%0d_y", k), 32'(y_b), 32'hFF00);
      cfg_origin_x = 16'(16'h0100 * (k + 2));
    end
    enable_b = 1'b0;
    tick();
    check_val("b_stop_valid", 32'(valid_b), 32'd0);
    check_val("b_stop_busy", 32'(busy_b), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
